// File: rtl/parser_stage_pipe.sv
// rtl/parser_stage_pipe.sv - two-stage ternary-match header parser stage with programmable tables; PARSER_STATS_EN adds hit/miss counters
module parser_stage_pipe #(
    parameter int HDR_W  = 2048,
    parameter int KEY_W  = 144,
    parameter int OFF_W  = 12,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HDR_W-1:0]  in_hdr,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HDR_W-1:0]  out_hdr,
    output logic [KEY_W-1:0]  out_key,
    output logic [OFF_W-1:0]  out_off,
    output logic              out_done,
    output logic              out_miss,
    output logic              out_err,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [KEY_W-1:0]  cfg_wdata,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_miss
);
    localparam int ENTRIES = 2 ** ADDR_W;
    localparam int ACT_W   = 3 * OFF_W + 15;
    localparam int SW      = OFF_W + 8;
    // action word field positions, MSB first: done, key_pos, key_len, len_pos, len_bits, len_unit, len_const
    localparam int LC_LSB  = 0;
    localparam int LU_LSB  = OFF_W;
    localparam int LB_LSB  = OFF_W + 2;
    localparam int LP_LSB  = OFF_W + 6;
    localparam int KL_LSB  = 2 * OFF_W + 6;
    localparam int KP_LSB  = 2 * OFF_W + 14;
    localparam int DN_BIT  = 3 * OFF_W + 14;

    logic [KEY_W-1:0]   tbl_value  [ENTRIES];
    logic [KEY_W-1:0]   tbl_mask   [ENTRIES];
    logic [ACT_W-1:0]   tbl_action [ENTRIES];
    logic [ENTRIES-1:0] tbl_valid;

    logic               stall;
    logic               match_hit;
    logic [ADDR_W-1:0]  match_idx;

    logic               s1_valid;
    logic               s1_hit;
    logic [ADDR_W-1:0]  s1_idx;
    logic [HDR_W-1:0]   s1_hdr;
    logic [OFF_W-1:0]   s1_off;

    logic [ACT_W-1:0]   act;
    logic [OFF_W-1:0]   a_key_pos;
    logic [7:0]         a_key_len;
    logic [OFF_W-1:0]   a_len_pos;
    logic [3:0]         a_len_bits;
    logic [1:0]         a_len_unit;
    logic [OFF_W-1:0]   a_len_const;

    logic [SW-1:0]      key_p;
    logic [SW-1:0]      len_p;
    logic [15:0]        klen;
    logic [KEY_W-1:0]   key_win;
    logic [KEY_W-1:0]   ext_key;
    logic [15:0]        fld_win;
    logic [15:0]        fld;
    logic [2:0]         unit_sh;
    logic [SW-1:0]      nxt_off;
    logic               ext_err;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // table contents are not reset; software programs them before enabling entries
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            case (cfg_sel)
                2'b00:   tbl_value[cfg_addr]  <= cfg_wdata;
                2'b01:   tbl_mask[cfg_addr]   <= cfg_wdata;
                2'b10:   tbl_action[cfg_addr] <= cfg_wdata[ACT_W-1:0];
                default: ;
            endcase
        end
    end

    // entry-valid bits, the only table state cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_valid <= '0;
        end else if (cfg_we && cfg_sel == 2'b11) begin
            tbl_valid[cfg_addr] <= cfg_wdata[0];
        end
    end

    // ternary match on the incoming beat; scanning downward lets the lowest index win
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tbl_valid[i] && ((in_key ^ tbl_value[i]) & tbl_mask[i]) == '0) begin
                match_hit = 1'b1;
                match_idx = ADDR_W'(i);
            end
        end
    end

    // stage 1: capture the lookup result alongside the header and offset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_idx   <= '0;
            s1_hdr   <= '0;
            s1_off   <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_hit <= match_hit;
                s1_idx <= match_idx;
                s1_hdr <= in_hdr;
                s1_off <= in_off;
            end
        end
    end

    assign act         = tbl_action[s1_idx];
    assign a_key_pos   = act[KP_LSB +: OFF_W];
    assign a_key_len   = act[KL_LSB +: 8];
    assign a_len_pos   = act[LP_LSB +: OFF_W];
    assign a_len_bits  = act[LB_LSB +: 4];
    assign a_len_unit  = act[LU_LSB +: 2];
    assign a_len_const = act[LC_LSB +: OFF_W];

    // action evaluation: shifting the header left brings the wanted bit to the top, and bits past the window shift in as 0
    always_comb begin
        key_p   = SW'(s1_off) + SW'(a_key_pos);
        len_p   = SW'(s1_off) + SW'(a_len_pos);
        klen    = ({8'd0, a_key_len} > 16'(KEY_W)) ? 16'(KEY_W) : {8'd0, a_key_len};
        key_win = KEY_W'((s1_hdr << key_p) >> (HDR_W - KEY_W));
        ext_key = key_win >> (16'(KEY_W) - klen);
        fld_win = 16'((s1_hdr << len_p) >> (HDR_W - 16));
        fld     = fld_win >> (5'd16 - {1'b0, a_len_bits});
        case (a_len_unit)
            2'b00:   unit_sh = 3'd0;
            2'b01:   unit_sh = 3'd3;
            2'b10:   unit_sh = 3'd5;
            default: unit_sh = 3'd6;
        endcase
        nxt_off = SW'(s1_off) + SW'(a_len_const) + (SW'(fld) << unit_sh);
        ext_err = ((klen != 16'd0) && (key_p + SW'(klen) > SW'(HDR_W)))
                | ((a_len_bits != 4'd0) && (len_p + SW'(a_len_bits) > SW'(HDR_W)))
                | (nxt_off > SW'(HDR_W));
    end

    // stage 2: register the output beat; everything holds while downstream stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_hdr   <= '0;
            out_key   <= '0;
            out_off   <= '0;
            out_done  <= 1'b0;
            out_miss  <= 1'b0;
            out_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_hdr <= s1_hdr;
                if (s1_hit) begin
                    out_key  <= ext_key;
                    out_off  <= nxt_off[OFF_W-1:0];
                    out_done <= act[DN_BIT];
                    out_miss <= 1'b0;
                    out_err  <= ext_err;
                end else begin
                    out_key  <= '0;
                    out_off  <= s1_off;
                    out_done <= 1'b1;
                    out_miss <= 1'b1;
                    out_err  <= 1'b0;
                end
            end
        end
    end

`ifdef PARSER_STATS_EN
    // saturating counts of delivered beats, split by hit and miss
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits <= '0;
            stat_miss <= '0;
        end else if (out_valid && out_ready) begin
            if (out_miss) begin
                if (stat_miss != 32'hFFFF_FFFF) stat_miss <= stat_miss + 32'd1;
            end else begin
                if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
            end
        end
    end
`else
    assign stat_hits = '0;
    assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_parser_stage_pipe.sv
// tb/tb_parser_stage_pipe.sv - scoreboard bench for parser_stage_pipe
module tb_parser_stage_pipe;
    localparam int HDR_W   = 2048;
    localparam int KEY_W   = 144;
    localparam int OFF_W   = 12;
    localparam int ADDR_W  = 5;
    localparam int ENTRIES = 2 ** ADDR_W;

    typedef struct packed {
        logic [HDR_W-1:0] hdr;
        logic [KEY_W-1:0] key;
        logic [OFF_W-1:0] off;
        logic             done;
        logic             miss;
        logic             err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [HDR_W-1:0]  in_hdr;
    logic [KEY_W-1:0]  in_key;
    logic [OFF_W-1:0]  in_off;
    logic              out_valid;
    logic              out_ready;
    logic [HDR_W-1:0]  out_hdr;
    logic [KEY_W-1:0]  out_key;
    logic [OFF_W-1:0]  out_off;
    logic              out_done;
    logic              out_miss;
    logic              out_err;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [ADDR_W-1:0] cfg_addr;
    logic [KEY_W-1:0]  cfg_wdata;
    logic [31:0]       stat_hits;
    logic [31:0]       stat_miss;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_hit    = 0;
    int n_miss   = 0;
    int acc0;

    logic [KEY_W-1:0]   tval  [ENTRIES];
    logic [KEY_W-1:0]   tmask [ENTRIES];
    logic [KEY_W-1:0]   tact  [ENTRIES];
    logic [ENTRIES-1:0] tvld;

    exp_t sb[$];
    exp_t e;
    logic             prev_stall = 1'b0;
    logic [KEY_W-1:0] prev_key;
    logic [OFF_W-1:0] prev_off;
    logic             rnd_done;
    logic [HDR_W-1:0] h;
    logic [KEY_W-1:0] rk;

    parser_stage_pipe #(.HDR_W(HDR_W), .KEY_W(KEY_W), .OFF_W(OFF_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr), .in_key(in_key), .in_off(in_off),
        .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr), .out_key(out_key),
        .out_off(out_off), .out_done(out_done), .out_miss(out_miss), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .stat_hits(stat_hits), .stat_miss(stat_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] mk_act(input logic dn, input logic [11:0] kp, input logic [7:0] kl,
                                                input logic [11:0] lp, input logic [3:0] lb, input logic [1:0] lu,
                                                input logic [11:0] lc);
        return KEY_W'({dn, kp, kl, lp, lb, lu, lc});
    endfunction

    function automatic logic [HDR_W-1:0] rand_hdr();
        logic [HDR_W-1:0] r;
        for (int i = 0; i < HDR_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // reference: walks header bits one at a time, offset 0 being the MSB
    function automatic exp_t model(input logic [HDR_W-1:0] hh, input logic [KEY_W-1:0] k, input logic [OFF_W-1:0] o);
        exp_t r;
        int hit_i, p, lp, klen, lb, q, f, sum;
        logic [50:0] a;
        logic [KEY_W-1:0] kk;
        r = '0;
        r.hdr = hh;
        hit_i = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (hit_i < 0 && tvld[i] && (((k ^ tval[i]) & tmask[i]) == '0)) hit_i = i;
        if (hit_i < 0) begin
            r.miss = 1'b1;
            r.done = 1'b1;
            r.off  = o;
            return r;
        end
        a = tact[hit_i][50:0];
        r.done = a[50];
        p = int'(o) + int'(a[49:38]);
        klen = int'(a[37:30]);
        if (klen > KEY_W) klen = KEY_W;
        kk = '0;
        for (int i = 0; i < klen; i++) begin
            q = p + i;
            kk = {kk[KEY_W-2:0], (q < HDR_W) ? hh[HDR_W-1-q] : 1'b0};
            if (q >= HDR_W) r.err = 1'b1;
        end
        r.key = kk;
        lp = int'(o) + int'(a[29:18]);
        lb = int'(a[17:14]);
        f = 0;
        for (int i = 0; i < lb; i++) begin
            q = lp + i;
            f = f * 2 + ((q < HDR_W) ? int'(hh[HDR_W-1-q]) : 0);
            if (q >= HDR_W) r.err = 1'b1;
        end
        case (a[13:12])
            2'b00: f = f;
            2'b01: f = f * 8;
            2'b10: f = f * 32;
            default: f = f * 64;
        endcase
        sum = int'(o) + int'(a[11:0]) + f;
        if (sum > HDR_W) r.err = 1'b1;
        r.off = sum[OFF_W-1:0];
        return r;
    endfunction

    // monitor: handshakes evaluated at negedge, inputs only change just after posedge
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_key", out_key, e.key);
                    check("out_off", KEY_W'(out_off), KEY_W'(e.off));
                    check("out_done", KEY_W'(out_done), KEY_W'(e.done));
                    check("out_miss", KEY_W'(out_miss), KEY_W'(e.miss));
                    check("out_err", KEY_W'(out_err), KEY_W'(e.err));
                    check("out_hdr", KEY_W'(out_hdr == e.hdr), 1);
                    if (e.miss) n_miss++; else n_hit++;
                end
            end
            if (prev_stall) begin
                check("stall_valid", KEY_W'(out_valid), 1);
                check("stall_key", out_key, prev_key);
                check("stall_off", KEY_W'(out_off), KEY_W'(prev_off));
            end
            prev_stall = out_valid & ~out_ready;
            prev_key   = out_key;
            prev_off   = out_off;
            if (in_valid && in_ready) begin
                sb.push_back(model(in_hdr, in_key, in_off));
                n_acc++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cfg_write(input logic [1:0] s, input int a, input logic [KEY_W-1:0] d);
        cfg_we = 1'b1; cfg_sel = s; cfg_addr = a[ADDR_W-1:0]; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        case (s)
            2'b00: tval[a] = d;
            2'b01: tmask[a] = d;
            2'b10: tact[a] = d;
            default: tvld[a] = d[0];
        endcase
    endtask

    task automatic prog(input int a, input logic [KEY_W-1:0] v, input logic [KEY_W-1:0] m, input logic [KEY_W-1:0] ac);
        cfg_write(2'b00, a, v);
        cfg_write(2'b01, a, m);
        cfg_write(2'b10, a, ac);
        cfg_write(2'b11, a, 1);
    endtask

    task automatic send_beat(input logic [HDR_W-1:0] hd, input logic [KEY_W-1:0] k, input logic [OFF_W-1:0] o);
        bit acc = 1'b0;
        int budget = 0;
        in_hdr = hd; in_key = k; in_off = o; in_valid = 1'b1;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            budget++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() != 0 && b < 300) begin
            @(posedge clk);
            b++;
        end
        @(posedge clk); #1;
        check("drain_left", KEY_W'(sb.size()), 0);
    endtask

    task automatic check_stats();
`ifdef PARSER_STATS_EN
        check("stat_hits", KEY_W'(stat_hits), KEY_W'(n_hit));
        check("stat_miss", KEY_W'(stat_miss), KEY_W'(n_miss));
`else
        check("stat_hits", KEY_W'(stat_hits), 0);
        check("stat_miss", KEY_W'(stat_miss), 0);
`endif
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_hdr = '0; in_key = '0; in_off = '0;
        out_ready = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_wdata = '0;
        tvld = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", KEY_W'(out_valid), 0);
        check("rst_in_ready", KEY_W'(in_ready), 1);
        check("rst_out_key", out_key, 0);
        check("rst_out_off", KEY_W'(out_off), 0);
        check("rst_flags", KEY_W'({out_done, out_miss, out_err}), 0);
        check("rst_out_hdr", KEY_W'(out_hdr == '0), 1);
        check_stats();
        reset = 1'b1;
        @(posedge clk); #1;

        // IPv4 over Ethernet: ethertype at bytes 12..13, IHL nibble at bit 116
        prog(0, 'h0800, 'hFFFF, mk_act(1'b0, 12'd96, 8'd8, 12'd4, 4'd4, 2'b10, 12'd0));
        h = rand_hdr();
        h[HDR_W-1-8*12 -: 16] = 16'h0800;
        h[HDR_W-1-8*14 -: 8]  = 8'h45;
        h[HDR_W-1-8*23 -: 8]  = 8'h11;
        send_beat(h, 'h0800, 12'd112);
        drain();

        // overlapping entries: lowest index wins until it is invalidated
        prog(3, 'h1234, 'hFFFF, mk_act(1'b1, 12'd0, 8'd16, 12'd0, 4'd0, 2'b00, 12'd0));
        prog(7, 'h1234, 'hFFFF, mk_act(1'b0, 12'd8, 8'd32, 12'd0, 4'd8, 2'b01, 12'd100));
        send_beat(rand_hdr(), 'h1234, 12'd40);
        cfg_write(2'b11, 3, 0);
        send_beat(rand_hdr(), 'h1234, 12'd40);
        send_beat(rand_hdr(), 'hBEEF, 12'd333);
        drain();

        // window-edge entries, a clamped key length and a masked key
        prog(1, 'h00AA, 'hFFFF, mk_act(1'b1, 12'd0, 8'd16, 12'd0, 4'd0, 2'b00, 12'd0));
        prog(2, 'h00BB, 'hFFFF, mk_act(1'b0, 12'd0, 8'd0, 12'd0, 4'd0, 2'b00, 12'd8));
        prog(6, 'h00CC, 'hFFFF, mk_act(1'b0, 12'd0, 8'd0, 12'd0, 4'd0, 2'b00, 12'd16));
        prog(4, 'h4444, 'hFFFF, mk_act(1'b0, 12'd0, 8'd200, 12'd3, 4'd15, 2'b11, 12'd5));
        prog(5, 'h5500, 'hFF00, mk_act(1'b1, 12'd20, 8'd12, 12'd0, 4'd2, 2'b00, 12'd1));
        send_beat(rand_hdr(), 'h00AA, 12'd2040);
        send_beat(rand_hdr(), 'h00BB, 12'd2040);
        send_beat(rand_hdr(), 'h00CC, 12'd2040);
        send_beat(rand_hdr(), 'h4444, 12'd0);
        send_beat(rand_hdr(), 'h55E7, 12'd64);
        drain();

        // backpressure: three beats against a 5-cycle stall
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send_beat(rand_hdr(), 'h0800, 12'd10);
                send_beat(rand_hdr(), 'hBEEF, 12'd20);
                send_beat(rand_hdr(), 'h1234, 12'd30);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", KEY_W'(in_ready), 0);
                check("stall_accepted", KEY_W'(n_acc - acc0), 2);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // random stream with random downstream readiness
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    case ($urandom_range(0, 7))
                        0: rk = 'h0800;
                        1: rk = 'h1234;
                        2: rk = KEY_W'({8'h55, 8'($urandom)});
                        3: rk = 'h00AA;
                        4: rk = 'h00BB;
                        5: rk = 'h00CC;
                        6: rk = 'h4444;
                        default: rk = KEY_W'($urandom);
                    endcase
                    send_beat(rand_hdr(), rk, OFF_W'($urandom_range(0, 2100)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check_stats();

        // reset with beats in flight
        send_beat(rand_hdr(), 'h0800, 12'd0);
        send_beat(rand_hdr(), 'h1234, 12'd8);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", KEY_W'(out_valid), 0);
        check("midrst_in_ready", KEY_W'(in_ready), 1);
        sb.delete();
        n_hit = 0;
        n_miss = 0;
        tvld = '0;
        check_stats();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send_beat(rand_hdr(), 'h0800, 12'd112);
        drain();
        check_stats();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
